// File: rtl/input_port_ctrl_pkg.sv
// Shared definitions for the mesh router input port: port indices, flit field
// positions and controller FSM encodings.
// Pure declarations; no logic, no latency, no flow control of its own.
package input_port_ctrl_pkg;

  // Output port indices of the one-hot request vector {W,S,E,N,LOCAL}
  localparam int PORT_LOCAL = 0;
  localparam int PORT_N     = 1;
  localparam int PORT_E     = 2;
  localparam int PORT_S     = 3;
  localparam int PORT_W     = 4;
  localparam int NUM_PORTS  = 5;

  typedef logic [NUM_PORTS-1:0] port_vec_t;

  // Destination coordinates sit at the top of the flit: dest_x then dest_y
  function automatic int dest_x_msb(input int flit_width);
    return flit_width - 1;
  endfunction

  function automatic int dest_y_msb(input int flit_width, input int coord_w);
    return flit_width - 1 - coord_w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_REQ   = 2'd2
  } state_t;

endpackage

// File: rtl/input_port_ctrl_if.sv
// Bundle of the FIFO read side, allocator handshake and crossbar output.
// Wires only; timing is set by whoever drives each signal.
// master = the input-port controller, slave = FIFO/allocator/crossbar side.
interface input_port_ctrl_if #(
  parameter int FLIT_WIDTH = 16
);
  import input_port_ctrl_pkg::*;

  logic                  fifo_rd_valid;
  logic [FLIT_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_ready;
  port_vec_t             req;
  logic                  gnt;
  logic [FLIT_WIDTH-1:0] out_flit;
  logic                  out_valid;
  logic                  stall;

  modport master (
    input  fifo_rd_valid, fifo_rd_data, gnt,
    output fifo_rd_ready, req, out_flit, out_valid, stall
  );

  modport slave (
    output fifo_rd_valid, fifo_rd_data, gnt,
    input  fifo_rd_ready, req, out_flit, out_valid, stall
  );

endinterface

// File: rtl/input_port_ctrl_xy_route.sv
// Dimension-ordered XY routing: picks the one-hot output port for a destination.
// Purely combinational, zero latency.
// No flow control; result is only meaningful while the caller holds dest stable.
module xy_route_calc
  import input_port_ctrl_pkg::*;
#(
  parameter int COORD_W = 3,
  parameter int CUR_X   = 0,
  parameter int CUR_Y   = 0
) (
  input  logic [COORD_W-1:0] dest_x,
  input  logic [COORD_W-1:0] dest_y,
  output port_vec_t          route
);

  localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
  localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);

  // Resolve X first, then Y, else deliver locally
  always_comb begin
    route = '0;
    if (dest_x > CX)      route[PORT_E]     = 1'b1;
    else if (dest_x < CX) route[PORT_W]     = 1'b1;
    else if (dest_y > CY) route[PORT_N]     = 1'b1;
    else if (dest_y < CY) route[PORT_S]     = 1'b1;
    else                  route[PORT_LOCAL] = 1'b1;
  end

endmodule

// File: rtl/input_port_ctrl.sv
// Input-port controller: pops a flit, routes it XY, requests the allocator, emits on grant.
// Latency: pop -> req 2 cycles, gnt -> out_valid 1 cycle; one flit in flight at most.
// Holds req until gnt; pops only when the FIFO is non-empty and the slot is free.
module input_port_ctrl
  import input_port_ctrl_pkg::*;
#(
  parameter int FLIT_WIDTH  = 16,
  parameter int COORD_W     = 3,
  parameter int CUR_X       = 0,
  parameter int CUR_Y       = 0,
  parameter int STALL_LIMIT = 255
) (
  input logic                clk,
  input logic                reset,
  input_port_ctrl_if.master  link
);

  localparam int CNT_W = $clog2(STALL_LIMIT + 1);
  localparam int DX_MSB = dest_x_msb(FLIT_WIDTH);
  localparam int DY_MSB = dest_y_msb(FLIT_WIDTH, COORD_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_LIMIT);

  state_t                state;
  logic [FLIT_WIDTH-1:0] flit_reg;
  port_vec_t             route_reg;
  logic [CNT_W-1:0]      stall_cnt;
  logic [FLIT_WIDTH-1:0] out_flit_reg;
  logic                  out_valid_reg;
  port_vec_t             route_next;
  logic                  pop;

  // Route straight off the FIFO data; it is captured in FETCH when the data is valid
  xy_route_calc #(
    .COORD_W (COORD_W),
    .CUR_X   (CUR_X),
    .CUR_Y   (CUR_Y)
  ) u_route (
    .dest_x (link.fifo_rd_data[DX_MSB -: COORD_W]),
    .dest_y (link.fifo_rd_data[DY_MSB -: COORD_W]),
    .route  (route_next)
  );

  // Pop when idle, or in the grant cycle so the next fetch overlaps the send
  assign pop = link.fifo_rd_valid &&
               ((state == ST_IDLE) || ((state == ST_REQ) && link.gnt));

  assign link.fifo_rd_ready = pop;
  assign link.req           = route_reg;
  assign link.out_flit      = out_flit_reg;
  assign link.out_valid     = out_valid_reg;
  assign link.stall         = (stall_cnt == CNT_MAX);

  // Controller FSM with the held flit, its route and the stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      flit_reg      <= '0;
      route_reg     <= '0;
      stall_cnt     <= '0;
      out_flit_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (link.fifo_rd_valid) state <= ST_FETCH;
        end
        ST_FETCH: begin
          flit_reg  <= link.fifo_rd_data;
          route_reg <= route_next;
          stall_cnt <= '0;
          state     <= ST_REQ;
        end
        ST_REQ: begin
          if (link.gnt) begin
            out_valid_reg <= 1'b1;
            out_flit_reg  <= flit_reg;
            route_reg     <= '0;
            stall_cnt     <= '0;
            state         <= pop ? ST_FETCH : ST_IDLE;
          end else if (stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_port_ctrl.sv
// Directed bench for input_port_ctrl at router (3,3) with a queue-backed FIFO model.
// Inputs change and outputs are sampled 1-2 time units after the rising edge.
// Expected values are hand-computed per vector.
module tb_input_port_ctrl;

  logic clk;
  logic reset;

  input_port_ctrl_if #(.FLIT_WIDTH(16)) link ();

  input_port_ctrl #(
    .FLIT_WIDTH  (16),
    .COORD_W     (3),
    .CUR_X       (3),
    .CUR_Y       (3),
    .STALL_LIMIT (255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .link  (link)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [15:0] fifo_q[$];
  logic [15:0] out_q[$];
  int pop_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int x, input int y, input int pl);
    return {x[2:0], y[2:0], pl[9:0]};
  endfunction

  // One clock: the FIFO model pops on the strobe seen before the edge and
  // presents the data the cycle after; output pulses are logged.
  task automatic tick();
    logic popped;
    popped = link.fifo_rd_ready && !reset;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) fifo_q.delete();
    if (popped && fifo_q.size() != 0) begin
      link.fifo_rd_data = fifo_q.pop_front();
      pop_cyc.push_back(cyc - 1);
    end
    link.fifo_rd_valid = (fifo_q.size() != 0);
    if (link.out_valid) out_q.push_back(link.out_flit);
  endtask

  task automatic push(input logic [15:0] f);
    fifo_q.push_back(f);
    link.fifo_rd_valid = 1'b1;
    #1;
  endtask

  task automatic wait_req();
    for (int n = 0; n < 10 && link.req == 0; n++) tick();
  endtask

  task automatic run_route(input string tag, input logic [15:0] f, input int exp);
    push(f);
    wait_req();
    chk(tag, 32'(link.req), exp);
    link.gnt = 1'b1;
    tick();
    chk({tag, "_ov"}, 32'(link.out_valid), 1);
    chk({tag, "_flit"}, 32'(link.out_flit), 32'(f));
    link.gnt = 1'b0;
    tick();
  endtask

  initial begin
    logic [15:0] f1;
    logic [15:0] fl[3];
    int npop;
    logic req_stable;

    reset = 1'b1;
    link.gnt = 1'b0;
    link.fifo_rd_valid = 1'b0;
    link.fifo_rd_data = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_req", 32'(link.req), 0);
    chk("rst_out_valid", 32'(link.out_valid), 0);
    chk("rst_out_flit", 32'(link.out_flit), 0);
    chk("rst_stall", 32'(link.stall), 0);
    chk("rst_no_pop", 32'(link.fifo_rd_ready), 0);

    // 1: dest (5,1) from (3,3) -> E; pop c0, req c2, gnt c4, out c5
    f1 = mk(5, 1, 'h2A5);
    push(f1);
    chk("t1_pop_c0", 32'(link.fifo_rd_ready), 1);
    tick();
    chk("t1_fetch_no_pop", 32'(link.fifo_rd_ready), 0);
    chk("t1_req_c1", 32'(link.req), 0);
    tick();
    chk("t1_req_c2", 32'(link.req), 4);
    tick();
    tick();
    chk("t1_ov_c4", 32'(link.out_valid), 0);
    link.gnt = 1'b1;
    tick();
    chk("t1_ov_c5", 32'(link.out_valid), 1);
    chk("t1_flit_c5", 32'(link.out_flit), 32'(f1));
    chk("t1_req_drop", 32'(link.req), 0);
    link.gnt = 1'b0;
    tick();
    chk("t1_ov_pulse", 32'(link.out_valid), 0);
    chk("t1_flit_hold", 32'(link.out_flit), 32'(f1));

    // 2: route sweep
    run_route("t2_w", mk(1, 3, 'h011), 16);
    run_route("t2_n", mk(3, 6, 'h022), 2);
    run_route("t2_s", mk(3, 0, 'h033), 8);
    run_route("t2_local", mk(3, 3, 'h044), 1);
    run_route("t2_e", mk(7, 0, 'h055), 4);

    // 3: back-to-back with gnt tied high
    out_q.delete();
    pop_cyc.delete();
    fl[0] = mk(6, 2, 'h101);
    fl[1] = mk(0, 5, 'h202);
    fl[2] = mk(3, 3, 'h303);
    for (int i = 0; i < 3; i++) push(fl[i]);
    link.gnt = 1'b1;
    repeat (12) tick();
    link.gnt = 1'b0;
    chk("t3_out_count", 32'(out_q.size()), 3);
    chk("t3_pop_count", 32'(pop_cyc.size()), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t3_order%0d", i),
          (out_q.size() > i) ? 32'(out_q[i]) : 32'hDEAD, 32'(fl[i]));
    if (pop_cyc.size() == 3) begin
      chk("t3_pop_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 2);
      chk("t3_pop_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 2);
    end
    tick();

    // 4: grant withheld 300 cycles, stall from REQ cycle 255
    push(mk(0, 7, 'h3FF));
    wait_req();
    req_stable = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (k == 0)   chk("t4_stall_k0", 32'(link.stall), 0);
      if (k == 254) chk("t4_stall_k254", 32'(link.stall), 0);
      if (k == 255) chk("t4_stall_k255", 32'(link.stall), 1);
      if (k == 299) chk("t4_stall_k299", 32'(link.stall), 1);
      if (link.req != 5'b10000) req_stable = 1'b0;
      tick();
    end
    chk("t4_req_stable", 32'(req_stable), 1);
    link.gnt = 1'b1;
    tick();
    chk("t4_stall_clear", 32'(link.stall), 0);
    chk("t4_ov", 32'(link.out_valid), 1);
    link.gnt = 1'b0;
    tick();

    // 5: FIFO empty at grant -> no pop, back to IDLE
    push(mk(2, 2, 'h0AA));
    wait_req();
    link.gnt = 1'b1;
    #1;
    chk("t5_no_pop", 32'(link.fifo_rd_ready), 0);
    npop = pop_cyc.size();
    tick();
    link.gnt = 1'b0;
    chk("t5_req0_a", 32'(link.req), 0);
    tick();
    chk("t5_req0_b", 32'(link.req), 0);
    chk("t5_pop_unchanged", 32'(pop_cyc.size()), 32'(npop));
    push(mk(4, 4, 'h0BB));
    chk("t5_idle_pops", 32'(link.fifo_rd_ready), 1);
    wait_req();
    link.gnt = 1'b1;
    tick();
    link.gnt = 1'b0;
    tick();

    // 6: reset while requesting drops the flit
    push(mk(5, 1, 'h1C3));
    wait_req();
    chk("t6_req_pre", 32'(link.req), 4);
    reset = 1'b1;
    tick();
    chk("t6_req", 32'(link.req), 0);
    chk("t6_ov", 32'(link.out_valid), 0);
    chk("t6_stall", 32'(link.stall), 0);
    reset = 1'b0;
    out_q.delete();
    link.gnt = 1'b1;
    repeat (4) tick();
    link.gnt = 1'b0;
    chk("t6_no_out", 32'(out_q.size()), 0);
    chk("t6_req_idle", 32'(link.req), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
